// File: rtl/local_store_arbiter.sv
// local_store_arbiter
//   Arbitrates a single-ported quadword data memory between the load/store unit (LSU) and a
//   DMA engine. At most one requester is granted per cycle; LSU wins by default. A granted
//   in-range access is forwarded to the memory in the same cycle. Read data and error pulses
//   come back one cycle later and are steered to whoever was granted.
//
//   Optional feature macro: LS_ARB_STARVE_EN
//     Defined   - a DMA wait counter forces a DMA grant once DMA has waited STARVE_MAX cycles.
//     Undefined - strict LSU priority, no counter.
//
// Ports
//   clk, reset                  single clock, synchronous active-high reset
//   lsu_* / dma_* inputs        req, we (1 = write), byte addr, wdata; held until gnt
//   lsu_gnt / dma_gnt           combinational accept
//   lsu_rvalid / dma_rvalid     registered read-data valid (T+1 after grant)
//   lsu_rdata / dma_rdata       read data, zero whenever rvalid is low
//   lsu_err / dma_err           registered out-of-range pulse (T+1 after grant)
//   mem_address .. mem_memRead  memory command, all zero on idle cycles
//   mem_readData                memory read result, valid one cycle after mem_memRead
module local_store_arbiter #(
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned MEM_DEPTH  = 2001,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lsu_req,
  input  logic              lsu_we,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              lsu_gnt,
  output logic              dma_gnt,
  output logic              lsu_rvalid,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              lsu_err,
  output logic              dma_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writeData,
  output logic              mem_memWrite,
  output logic              mem_memRead,
  input  logic [DATA_W-1:0] mem_readData
);

  localparam logic [ADDR_W-1:0] DepthA = ADDR_W'(MEM_DEPTH);

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnLsu  = 2'd1,
    OwnDma  = 2'd2
  } owner_e;

  owner_e owner_q, owner_d;
  logic   rvalid_q, rvalid_d;
  logic   err_q, err_d;
  logic   rd_mem_q, rd_mem_d;   // last read really went to memory (else rdata is zero)

  logic              starve_hit;
  logic              any_gnt;
  logic              sel_we;
  logic              sel_in;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef LS_ARB_STARVE_EN
  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

  logic [CntW-1:0] starve_q, starve_d;

  // Counts consecutive cycles DMA is requesting but not granted.
  always_comb begin
    starve_d = '0;
    if (dma_req && !dma_gnt) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign starve_hit = (starve_q == CntW'(STARVE_MAX));
`else
  logic unused_starve_max;
  assign unused_starve_max = |STARVE_MAX;
  assign starve_hit        = 1'b0;
`endif

  // Grant decision: nothing is accepted while in reset.
  always_comb begin
    lsu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (!reset) begin
      if (dma_req && starve_hit) begin
        dma_gnt = 1'b1;
      end else if (lsu_req) begin
        lsu_gnt = 1'b1;
      end else if (dma_req) begin
        dma_gnt = 1'b1;
      end
    end
  end

  assign any_gnt   = lsu_gnt | dma_gnt;
  assign sel_we    = lsu_gnt ? lsu_we    : dma_we;
  assign sel_addr  = lsu_gnt ? lsu_addr  : dma_addr;
  assign sel_wdata = lsu_gnt ? lsu_wdata : dma_wdata;
  assign sel_in    = (sel_addr >> 4) < DepthA;

  // Memory command: only in-range grants reach the memory.
  always_comb begin
    mem_address   = '0;
    mem_writeData = '0;
    mem_memWrite  = 1'b0;
    mem_memRead   = 1'b0;
    if (any_gnt && sel_in) begin
      mem_address   = sel_addr;
      mem_writeData = sel_wdata;
      mem_memWrite  = sel_we;
      mem_memRead   = !sel_we;
    end
  end

  always_comb begin
    owner_d  = OwnNone;
    if (lsu_gnt) begin
      owner_d = OwnLsu;
    end else if (dma_gnt) begin
      owner_d = OwnDma;
    end
    rvalid_d = any_gnt && !sel_we;
    err_d    = any_gnt && !sel_in;
    rd_mem_d = any_gnt && !sel_we && sel_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q  <= OwnNone;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rd_mem_q <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rd_mem_q <= rd_mem_d;
    end
  end

  // Responses are masked while reset is high so a read in flight when reset arrives never
  // surfaces, whichever edge reset is first sampled on.
  always_comb begin
    lsu_rvalid = !reset && rvalid_q && (owner_q == OwnLsu);
    dma_rvalid = !reset && rvalid_q && (owner_q == OwnDma);
    lsu_err    = !reset && err_q && (owner_q == OwnLsu);
    dma_err    = !reset && err_q && (owner_q == OwnDma);
    lsu_rdata  = '0;
    dma_rdata  = '0;
    if (lsu_rvalid && rd_mem_q) begin
      lsu_rdata = mem_readData;
    end
    if (dma_rvalid && rd_mem_q) begin
      dma_rdata = mem_readData;
    end
  end

endmodule

// File: tb/tb_local_store_arbiter.sv
// Testbench for local_store_arbiter: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a transaction-level model.
module tb_local_store_arbiter;

  localparam int unsigned DW    = 128;
  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 2001;
  localparam int unsigned SMAX  = 8;
`ifdef LS_ARB_STARVE_EN
  localparam bit StarveOn = 1'b1;
`else
  localparam bit StarveOn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          lsu_req = 1'b0, lsu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
  logic [AW-1:0] lsu_addr = '0, dma_addr = '0;
  logic [DW-1:0] lsu_wdata = '0, dma_wdata = '0;
  logic          lsu_gnt, dma_gnt, lsu_rvalid, dma_rvalid, lsu_err, dma_err;
  logic [DW-1:0] lsu_rdata, dma_rdata;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_writeData;
  logic          mem_memWrite, mem_memRead;
  logic [DW-1:0] mem_readData = '0;

  local_store_arbiter #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .MEM_DEPTH (DEPTH),
    .STARVE_MAX(SMAX)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .lsu_req      (lsu_req),
    .lsu_we       (lsu_we),
    .lsu_addr     (lsu_addr),
    .lsu_wdata    (lsu_wdata),
    .dma_req      (dma_req),
    .dma_we       (dma_we),
    .dma_addr     (dma_addr),
    .dma_wdata    (dma_wdata),
    .lsu_gnt      (lsu_gnt),
    .dma_gnt      (dma_gnt),
    .lsu_rvalid   (lsu_rvalid),
    .dma_rvalid   (dma_rvalid),
    .lsu_rdata    (lsu_rdata),
    .dma_rdata    (dma_rdata),
    .lsu_err      (lsu_err),
    .dma_err      (dma_err),
    .mem_address  (mem_address),
    .mem_writeData(mem_writeData),
    .mem_memWrite (mem_memWrite),
    .mem_memRead  (mem_memRead),
    .mem_readData (mem_readData)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Memory the DUT talks to; returns junk when no read was issued.
  logic [DW-1:0] env_mem [DEPTH];
  always @(posedge clk) begin
    int unsigned ei;
    ei = int'(mem_address >> 4);
    if (mem_memWrite && ei < DEPTH) env_mem[ei] <= mem_writeData;
    if (mem_memRead && ei < DEPTH) mem_readData <= env_mem[ei];
    else mem_readData <= {$urandom, $urandom, $urandom, $urandom};
  end

  // Reference model: memory contents, pending responses, DMA wait streak.
  logic [DW-1:0] ref_mem [DEPTH];
  bit            m_lrv = 0, m_lerr = 0, m_drv = 0, m_derr = 0;
  logic [DW-1:0] m_lrd = '0, m_drd = '0;
  int unsigned   m_wait = 0;

  always @(negedge clk) begin : compare
    bit            eg_l, eg_d, e_we, e_in, cmd;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    int unsigned   idx;
    eg_l = 0;
    eg_d = 0;
    if (!reset) begin
      if (StarveOn && dma_req && m_wait == SMAX) eg_d = 1;
      else if (lsu_req) eg_l = 1;
      else if (dma_req) eg_d = 1;
    end
    e_we   = eg_l ? lsu_we : dma_we;
    e_addr = eg_l ? lsu_addr : dma_addr;
    e_wd   = eg_l ? lsu_wdata : dma_wdata;
    idx    = e_addr / 16;
    e_in   = idx < DEPTH;
    cmd    = (eg_l || eg_d) && e_in;

    chk("lsu_gnt", lsu_gnt, eg_l);
    chk("dma_gnt", dma_gnt, eg_d);
    chk("mem_address", mem_address, cmd ? e_addr : '0);
    chk("mem_writeData", mem_writeData, cmd ? e_wd : '0);
    chk("mem_memWrite", mem_memWrite, cmd && e_we);
    chk("mem_memRead", mem_memRead, cmd && !e_we);
    chk("lsu_rvalid", lsu_rvalid, !reset && m_lrv);
    chk("lsu_rdata", lsu_rdata, reset ? '0 : m_lrd);
    chk("lsu_err", lsu_err, !reset && m_lerr);
    chk("dma_rvalid", dma_rvalid, !reset && m_drv);
    chk("dma_rdata", dma_rdata, reset ? '0 : m_drd);
    chk("dma_err", dma_err, !reset && m_derr);

    if (reset) begin
      m_lrv = 0; m_lerr = 0; m_drv = 0; m_derr = 0;
      m_lrd = '0; m_drd = '0; m_wait = 0;
    end else begin
      m_lrv  = eg_l && !e_we;
      m_lerr = eg_l && !e_in;
      m_lrd  = (eg_l && !e_we && e_in) ? ref_mem[idx] : '0;
      m_drv  = eg_d && !e_we;
      m_derr = eg_d && !e_in;
      m_drd  = (eg_d && !e_we && e_in) ? ref_mem[idx] : '0;
      if (cmd && e_we) ref_mem[idx] = e_wd;
      m_wait = (dma_req && !eg_d) ? m_wait + 1 : 0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    lsu_req = 0; lsu_we = 0; lsu_addr = '0; lsu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
  endtask

  task automatic new_req(output logic we, output logic [AW-1:0] a, output logic [DW-1:0] d);
    int unsigned r, q;
    r = $urandom_range(0, 99);
    if (r < 70) q = $urandom_range(0, 15);
    else if (r < 85) q = $urandom_range(1995, 2000);
    else if (r < 95) q = $urandom_range(2001, 2010);
    else q = $urandom_range(2011, 32'h0FFF_FFFF);
    a  = (q << 4) | $urandom_range(0, 15);
    we = 1'($urandom_range(0, 1));
    d  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  bit l_took = 0, d_took = 0;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      env_mem[i] = '0;
      ref_mem[i] = '0;
    end

    // Reset with requests pending: everything ignored.
    lsu_req = 1; dma_req = 1;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_lsu_gnt", lsu_gnt, 0);
    chk("rst_dma_gnt", dma_gnt, 0);
    chk("rst_memRead", mem_memRead, 0);
    chk("rst_lsu_rvalid", lsu_rvalid, 0);
    tick(); reset = 0; idle();

    // Write 120 to 0x10 then read it back.
    tick(); lsu_req = 1; lsu_we = 1; lsu_addr = 32'h10; lsu_wdata = 128'd120;
    @(negedge clk);
    chk("s33_wr_gnt", lsu_gnt, 1);
    chk("s33_memWrite", mem_memWrite, 1);
    tick(); lsu_we = 0;
    @(negedge clk);
    chk("s33_memRead", mem_memRead, 1);
    chk("s33_wr_no_rvalid", lsu_rvalid, 0);
    tick(); lsu_req = 0;
    @(negedge clk);
    chk("s33_rvalid", lsu_rvalid, 1);
    chk("s33_rdata", lsu_rdata, 128'd120);

    // Simultaneous requests: LSU first, DMA next.
    tick(); lsu_req = 1; lsu_addr = 32'h20; dma_req = 1; dma_addr = 32'h10;
    @(negedge clk);
    chk("s34_lsu_gnt", lsu_gnt, 1);
    chk("s34_dma_wait", dma_gnt, 0);
    tick(); lsu_req = 0;
    @(negedge clk);
    chk("s34_dma_gnt", dma_gnt, 1);
    chk("s34_lsu_rvalid", lsu_rvalid, 1);
    tick(); dma_req = 0;
    @(negedge clk);
    chk("s34_dma_rvalid", dma_rvalid, 1);
    chk("s34_dma_rdata", dma_rdata, 128'd120);

    // Out-of-range DMA read (index 2001).
    tick(); dma_req = 1; dma_addr = 32'h7D10;
    @(negedge clk);
    chk("s35_gnt", dma_gnt, 1);
    chk("s35_memRead", mem_memRead, 0);
    tick(); dma_req = 0;
    @(negedge clk);
    chk("s35_rvalid", dma_rvalid, 1);
    chk("s35_err", dma_err, 1);
    chk("s35_rdata", dma_rdata, '0);

    // Alternating LSU/DMA reads with no bubbles.
    tick(); lsu_req = 1; lsu_addr = 32'h0;
    @(negedge clk);
    chk("s38_g0", lsu_gnt, 1);
    tick(); lsu_req = 0; dma_req = 1; dma_addr = 32'h10;
    @(negedge clk);
    chk("s38_g1", dma_gnt, 1);
    chk("s38_lrv0", lsu_rvalid, 1);
    tick(); dma_req = 0; lsu_req = 1; lsu_addr = 32'h20;
    @(negedge clk);
    chk("s38_g2", lsu_gnt, 1);
    chk("s38_drv1", dma_rvalid, 1);
    chk("s38_drd1", dma_rdata, 128'd120);
    chk("s38_lrv_off", lsu_rvalid, 0);
    tick(); lsu_req = 0; dma_req = 1; dma_addr = 32'h30;
    @(negedge clk);
    chk("s38_g3", dma_gnt, 1);
    chk("s38_lrv2", lsu_rvalid, 1);
    tick(); idle();
    @(negedge clk);
    chk("s38_drv3", dma_rvalid, 1);

    // Reset right after a read grant kills the response.
    tick(); lsu_req = 1; lsu_addr = 32'h10;
    @(negedge clk);
    chk("s37_gnt", lsu_gnt, 1);
    tick(); reset = 1;
    @(negedge clk);
    chk("s37_rvalid_rst", lsu_rvalid, 0);
    chk("s37_gnt_rst", lsu_gnt, 0);
    chk("s37_memRead", mem_memRead, 0);
    chk("s37_memAddr", mem_address, '0);
    tick(); reset = 0; idle();
    @(negedge clk);
    chk("s37_rvalid_after", lsu_rvalid, 0);

`ifdef LS_ARB_STARVE_EN
    // Continuous LSU traffic: DMA gets through on its 9th waiting cycle.
    tick(); lsu_req = 1; lsu_addr = 32'h0; dma_req = 1; dma_addr = 32'h20;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk("s36_dma_gnt", dma_gnt, k == 9);
      chk("s36_lsu_gnt", lsu_gnt, k != 9);
      if (k < 9) tick();
    end
    tick(); idle();
`endif

    // Randomized traffic with occasional reset pulses.
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (l_took) lsu_req = 0;
      if (d_took) dma_req = 0;
      if (!lsu_req && $urandom_range(0, 3) != 0) begin
        new_req(lsu_we, lsu_addr, lsu_wdata);
        lsu_req = 1;
      end
      if (!dma_req && $urandom_range(0, 2) != 0) begin
        new_req(dma_we, dma_addr, dma_wdata);
        dma_req = 1;
      end
      reset = ($urandom_range(0, 299) == 0);
      @(negedge clk);
      l_took = lsu_gnt;
      d_took = dma_gnt;
    end
    tick(); idle(); reset = 0;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
